// File: rtl/cl_pkg.sv
// Shared types and constants for the Camera Link capture front-end.
// Holds the FSM state enum, a width helper and the default line/frame geometry.
package cl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StSkip
  } cl_state_e;

  localparam int unsigned DefHact  = 640;
  localparam int unsigned DefVact  = 480;
  localparam int unsigned DefNtaps = 2;
  localparam int unsigned DefNch   = 6;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int unsigned cl_clog2(input int unsigned value);
    int unsigned w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cl_binarize.sv
// Combinational comparator array: every tap of a beat against every channel threshold.
// Output bit [k*NCH + c] is 1 when tap k is >= threshold c (unsigned).
module cl_binarize #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned NTAPS       = 2,
  parameter int unsigned NCH         = 6
) (
  input  logic [NTAPS*PIXEL_WIDTH-1:0] pix_i,
  input  logic [NCH*PIXEL_WIDTH-1:0]   thr_i,
  output logic [NTAPS*NCH-1:0]         bits_o
);

  always_comb begin
    bits_o = '0;
    for (int k = 0; k < NTAPS; k++) begin
      for (int c = 0; c < NCH; c++) begin
        bits_o[k*NCH+c] = (pix_i[k*PIXEL_WIDTH +: PIXEL_WIDTH] >=
                           thr_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/cl_frame_capture.sv
// Camera Link capture: binarises each line into NCH planes and strobes it into the
// ping-pong line memory bank not being displayed, with per-frame arming and checks.
module cl_frame_capture
  import cl_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned NTAPS       = DefNtaps,
  parameter int unsigned HACT        = DefHact,
  parameter int unsigned VACT        = DefVact,
  parameter int unsigned NCH         = DefNch,
  parameter int unsigned ROW_WIDTH   = 10
) (
  input  logic                         CCLK,
  input  logic                         RST_N,
  input  logic                         iFVAL,
  input  logic                         iLVAL,
  input  logic                         iDVAL,
  input  logic [NTAPS*PIXEL_WIDTH-1:0] iDATA,
  input  logic [NCH*PIXEL_WIDTH-1:0]   iTHRESHOLD,
  input  logic                         iCAPTURE_EN,
  input  logic                         iRD_BANK,
  output logic                         oWE,
  output logic                         oWR_BANK,
  output logic [ROW_WIDTH-1:0]         oROW,
  output logic [NCH*HACT-1:0]          oMEMIN,
  output logic                         oFRAME_DONE,
  output logic                         oLINE_ERR,
  output logic                         oBUSY
);

  localparam int unsigned CntMax = HACT + NTAPS;
  localparam int unsigned CntW   = cl_clog2(CntMax + 1);
  localparam int unsigned RowW   = cl_clog2(VACT + 1);
  localparam int unsigned IdxW   = cl_clog2(NCH * HACT);

  cl_state_e             state_q, state_d;
  logic                  fval_q, lval_q, armed_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [NCH*HACT-1:0]   line_q, line_d;
  logic                  ferr_q, ferr_d;
  logic                  we_q, we_d;
  logic                  bank_q, bank_d;
  logic [ROW_WIDTH-1:0]  orow_q, orow_d;
  logic [NCH*HACT-1:0]   memin_q, memin_d;
  logic                  done_q, done_d;
  logic                  lerr_q, lerr_d;
  logic                  busy_q;

  logic                  fval_rise, fval_fall, lval_fall, beat;
  logic [NTAPS*NCH-1:0]  beat_bits;

  cl_binarize #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .NTAPS       (NTAPS),
    .NCH         (NCH)
  ) u_binarize (
    .pix_i  (iDATA),
    .thr_i  (iTHRESHOLD),
    .bits_o (beat_bits)
  );

  // armed_q blocks a frame already in progress when reset released.
  assign fval_rise = iFVAL & ~fval_q & armed_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign lval_fall = ~iLVAL & lval_q;
  assign beat      = iFVAL & iLVAL & iDVAL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    line_d  = line_q;
    ferr_d  = ferr_q;
    we_d    = 1'b0;
    bank_d  = bank_q;
    orow_d  = orow_q;
    memin_d = memin_q;
    done_d  = 1'b0;
    lerr_d  = lerr_q;
    unique case (state_q)
      StIdle: begin
        if (fval_rise) begin
          if (iCAPTURE_EN) begin
            state_d = StCapture;
            bank_d  = ~iRD_BANK;
            row_d   = '0;
            cnt_d   = '0;
            ferr_d  = 1'b0;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StSkip: begin
        if (fval_fall) state_d = StIdle;
      end
      StCapture: begin
        if (beat) begin
          if (cnt_q < CntW'(HACT)) begin
            for (int c = 0; c < NCH; c++) begin
              for (int k = 0; k < NTAPS; k++) begin
                line_d[IdxW'(c*HACT + k + int'(cnt_q))] = beat_bits[k*NCH+c];
              end
            end
            cnt_d = cnt_q + CntW'(NTAPS);
          end else begin
            cnt_d = CntW'(CntMax);
          end
        end
        // beat and lval_fall are exclusive: a beat needs iLVAL high.
        if (lval_fall) begin
          if (cnt_q == CntW'(HACT)) begin
            if (row_q < RowW'(VACT)) begin
              we_d    = 1'b1;
              orow_d  = ROW_WIDTH'(row_q);
              memin_d = line_q;
            end
          end else begin
            lerr_d = 1'b1;
            ferr_d = 1'b1;
          end
          if (row_q < RowW'(VACT)) row_d = row_q + 1'b1;
          cnt_d = '0;
        end
        if (fval_fall) begin
          state_d = StIdle;
          done_d  = ~ferr_d & (row_d == RowW'(VACT));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      row_q   <= '0;
      line_q  <= '0;
      ferr_q  <= 1'b0;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      orow_q  <= '0;
      memin_q <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      lval_q  <= iLVAL & iFVAL;
      armed_q <= armed_q | ~iFVAL;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      line_q  <= line_d;
      ferr_q  <= ferr_d;
      we_q    <= we_d;
      bank_q  <= bank_d;
      orow_q  <= orow_d;
      memin_q <= memin_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
      busy_q  <= (state_d == StCapture);
    end
  end

  assign oWE         = we_q;
  assign oWR_BANK    = bank_q;
  assign oROW        = orow_q;
  assign oMEMIN      = memin_q;
  assign oFRAME_DONE = done_q;
  assign oLINE_ERR   = lerr_q;
  assign oBUSY       = busy_q;

endmodule

// File: tb/tb_cl_frame_capture.sv
// Directed frame sequence with random pixels and DVAL gaps, checked against a
// line-level reference model of which rows get written and with what planes.
module tb_cl_frame_capture;

  localparam int PW = 8;
  localparam int NT = 2;
  localparam int HA = 16;
  localparam int VA = 8;
  localparam int NC = 6;
  localparam int RW = 4;
  localparam int IW = $clog2(NC * HA);

  logic              CCLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic              cap_en = 1'b0, rd_bank = 1'b0;
  logic [NT*PW-1:0]  data = '0;
  logic [NC*PW-1:0]  thr = '0;
  logic              we, wr_bank, done, lerr, busy;
  logic [RW-1:0]     row;
  logic [NC*HA-1:0]  memin;

  always #5 CCLK = ~CCLK;

  cl_frame_capture #(
    .PIXEL_WIDTH (PW),
    .NTAPS       (NT),
    .HACT        (HA),
    .VACT        (VA),
    .NCH         (NC),
    .ROW_WIDTH   (RW)
  ) dut (
    .CCLK        (CCLK),
    .RST_N       (RST_N),
    .iFVAL       (fval),
    .iLVAL       (lval),
    .iDVAL       (dval),
    .iDATA       (data),
    .iTHRESHOLD  (thr),
    .iCAPTURE_EN (cap_en),
    .iRD_BANK    (rd_bank),
    .oWE         (we),
    .oWR_BANK    (wr_bank),
    .oROW        (row),
    .oMEMIN      (memin),
    .oFRAME_DONE (done),
    .oLINE_ERR   (lerr),
    .oBUSY       (busy)
  );

  typedef struct packed {
    logic [RW-1:0]    row;
    logic             bank;
    logic [NC*HA-1:0] data;
  } wr_t;

  // Observation log, written only here.
  wr_t obs_q[$];
  int  done_cnt = 0, done_we_cnt = 0, busy_cyc = 0;

  always @(negedge CCLK) begin
    if (we) obs_q.push_back({row, wr_bank, memin});
    if (done) done_cnt++;
    if (done && we) done_we_cnt++;
    if (busy) busy_cyc++;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CCLK);
    #1;
  endtask

  logic [7:0] thr_v [NC];
  int   pix_mode = 0;
  int   bad_a = -1, len_a = HA, bad_b = -1, len_b = HA;
  logic exp_bank = 1'b0;
  logic exp_lerr = 1'b0;

  function automatic int line_len(input int i);
    if (i == bad_a) return len_a;
    if (i == bad_b) return len_b;
    return HA;
  endfunction

  task automatic load_thr();
    for (int c = 0; c < NC; c++) thr[c*PW +: PW] = thr_v[c];
  endtask

  task automatic run_frame(input string name, input bit en, input int nlines,
                           input bit sim_fall, input int rst_line);
    logic [7:0]       pix [HA+2*NT];
    wr_t              exp_q[$];
    wr_t              e;
    logic [NC*HA-1:0] w;
    int  base, d0, dw0, b0, len;
    bit  err, aborted;
    base = obs_q.size(); d0 = done_cnt; dw0 = done_we_cnt; b0 = busy_cyc;
    err = 0; aborted = 0;
    if (en) exp_bank = ~rd_bank;
    cap_en = en; fval = 1'b1;
    step(); step();
    for (int i = 0; i < nlines; i++) begin
      if (i == rst_line) begin
        RST_N = 1'b0;
        @(posedge CCLK);
        @(negedge CCLK);
        check({name, " reset outs"}, 128'({we, wr_bank, row, done, lerr, busy}), 128'(0));
        check({name, " reset memin"}, 128'(memin), 128'(0));
        RST_N = 1'b1;
        aborted = 1; exp_lerr = 1'b0; exp_bank = 1'b0;
        step();
      end
      len = line_len(i);
      for (int x = 0; x < len; x++) begin
        if (pix_mode == 0)      pix[x] = 8'($urandom);
        else if (pix_mode == 1) pix[x] = (x % 2 == 1) ? 8'h80 : 8'h7F;
        else                    pix[x] = 8'h35;
      end
      lval = 1'b1;
      for (int b = 0; b < len / NT; b++) begin
        while ($urandom_range(3) == 0) begin
          dval = 1'b0; data = NT*PW'($urandom); step();
        end
        dval = 1'b1;
        for (int k = 0; k < NT; k++) data[k*PW +: PW] = pix[b*NT+k];
        step();
      end
      dval = 1'b0; lval = 1'b0;
      if (sim_fall && i == nlines - 1) fval = 1'b0;
      step(); step(); step();
      if (en && !aborted) begin
        if (len != HA) begin
          err = 1; exp_lerr = 1'b1;
        end else if (i < VA) begin
          w = '0;
          for (int c = 0; c < NC; c++)
            for (int x = 0; x < HA; x++) w[IW'(c*HA + x)] = (pix[x] >= thr_v[c]);
          e.row = RW'(i); e.bank = exp_bank; e.data = w;
          exp_q.push_back(e);
        end
      end
    end
    fval = 1'b0; step();
    // Line activity with FVAL low must be ignored.
    lval = 1'b1; dval = 1'b1; data = NT*PW'($urandom); step(); step();
    lval = 1'b0; dval = 1'b0; step(); step();
    check({name, " write count"}, 128'(obs_q.size() - base), 128'(exp_q.size()));
    foreach (exp_q[j]) begin
      if (base + j < obs_q.size()) begin
        check({name, " row"},  128'(obs_q[base+j].row),  128'(exp_q[j].row));
        check({name, " bank"}, 128'(obs_q[base+j].bank), 128'(exp_q[j].bank));
        check({name, " data"}, 128'(obs_q[base+j].data), 128'(exp_q[j].data));
      end
    end
    check({name, " frame_done"}, 128'(done_cnt - d0),
          128'(en && !aborted && !err && nlines >= VA));
    check({name, " line_err"}, 128'(lerr), 128'(exp_lerr));
    check({name, " wr_bank"}, 128'(wr_bank), 128'(exp_bank));
    check({name, " busy seen"}, 128'(busy_cyc - b0 > 0), 128'(en));
    if (sim_fall) check({name, " done with we"}, 128'(done_we_cnt - dw0), 128'(1));
  endtask

  function automatic logic [NC*HA-1:0] last_word();
    if (obs_q.size() == 0) return '0;
    return obs_q[obs_q.size()-1].data;
  endfunction

  initial begin
    logic [NC*HA-1:0] k_alt, k_thr;
    int max_row, base;
    RST_N = 1'b0;
    step(); step(); step();
    @(negedge CCLK);
    check("init outs", 128'({we, wr_bank, row, done, lerr, busy}), 128'(0));
    check("init memin", 128'(memin), 128'(0));
    RST_N = 1'b1;
    step(); step();

    for (int c = 0; c < NC; c++) thr_v[c] = 8'h80;
    load_thr(); pix_mode = 1; rd_bank = 1'b0;
    run_frame("alt", 1'b1, VA, 1'b0, -1);
    k_alt = {NC{16'hAAAA}};
    check("alt pattern", 128'(last_word()), 128'(k_alt));

    for (int c = 0; c < NC; c++) thr_v[c] = 8'(8'h10 * (c + 1));
    load_thr(); pix_mode = 2;
    run_frame("thr", 1'b1, VA, 1'b0, -1);
    k_thr = {{(3*HA){1'b0}}, {(3*HA){1'b1}}};
    check("thr pattern", 128'(last_word()), 128'(k_thr));

    for (int c = 0; c < NC; c++) thr_v[c] = 8'($urandom);
    load_thr(); pix_mode = 0;
    bad_a = 5; len_a = HA - 2; bad_b = 6; len_b = HA + 2;
    run_frame("badlen", 1'b1, VA, 1'b0, -1);
    bad_a = -1; bad_b = -1;

    run_frame("skip", 1'b0, VA, 1'b0, -1);

    rd_bank = 1'b1;
    run_frame("bank", 1'b1, VA, 1'b0, -1);

    rd_bank = 1'b0;
    run_frame("rst", 1'b1, VA, 1'b0, 3);
    run_frame("after_rst", 1'b1, VA, 1'b0, -1);

    base = obs_q.size();
    run_frame("long", 1'b1, VA + 2, 1'b0, -1);
    max_row = 0;
    for (int j = base; j < obs_q.size(); j++)
      if (int'(obs_q[j].row) > max_row) max_row = int'(obs_q[j].row);
    check("long max row", 128'(max_row), 128'(VA - 1));

    for (int c = 0; c < NC; c++) thr_v[c] = 8'($urandom);
    load_thr();
    run_frame("simfall", 1'b1, VA, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
